// File: rtl/router_pkg.sv
// Shared router definitions: port count, field widths, default soft-reset
// timeout and the input-FSM state encodings. The router FSM, FIFOs and
// output-side sync logic all import this package.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;
  localparam int DATA_W    = 8;
  localparam int TIMEOUT   = 30;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } fsm_state_e;

endpackage

// File: rtl/router_timeout_ctr.sv
// Per-port read-timeout watchdog.
// Counts consecutive edges where the port is valid but not read. When the
// count reaches TIMEOUT it raises soft_reset for exactly one cycle and starts
// a new window, so a port that stays stuck pulses every TIMEOUT cycles.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   vld         : port data valid (FIFO not empty)
//   rd          : port read enable
//   soft_reset  : one-cycle soft reset pulse for this port's FIFO
module router_timeout_ctr #(
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= 1'b0;
      // Any read or empty edge restarts the whole window.
      if (!vld || rd) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt        <= '0;
        soft_reset <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_sync.sv
// Output-side sequencing for the 1xN router.
// Latches the header address, steers the FSM write enable to the addressed
// FIFO, returns that FIFO's full flag, drives per-port valid and runs one
// read-timeout watchdog per FIFO.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   detect_add     : FSM decoding header; datain holds destination address
//   datain         : header address
//   write_enb_reg  : FSM write request for current packet
//   read_enb       : per-port read enables
//   empty, full    : per-FIFO status flags
//   write_enb      : one-hot (or zero) FIFO write enable
//   fifo_full      : full flag of the addressed FIFO
//   vld_out        : per-port data valid
//   soft_reset     : per-FIFO one-cycle soft reset
//   addr_err       : one-cycle pulse on an out-of-range header address
module router_sync #(
  parameter int NUM_PORTS = router_pkg::NUM_PORTS,
  parameter int ADDR_W    = router_pkg::ADDR_W,
  parameter int TIMEOUT   = router_pkg::TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    datain,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
);

  import router_pkg::*;

  // One extra bit so NUM_PORTS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NP = (ADDR_W + 1)'(NUM_PORTS);

  logic [ADDR_W-1:0]    addr_reg;
  logic                 addr_valid;
  logic                 in_range;
  logic [NUM_PORTS-1:0] addr_hot;

  assign in_range = ({1'b0, datain} < NP);

  // Header latch. A write in the same cycle as detect_add still decodes on
  // the previous address; the new one applies from the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg   <= '0;
      addr_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      if (detect_add) begin
        addr_reg   <= datain;
        addr_valid <= in_range;
        addr_err   <= ~in_range;
      end
    end
  end

  // Decoded address is zero while no valid header is held, which keeps both
  // write_enb and fifo_full quiet after reset or an out-of-range header.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign addr_hot[i] = addr_valid & (addr_reg == ADDR_W'(i));

    router_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk        (clk),
      .reset      (reset),
      .vld        (vld_out[i]),
      .rd         (read_enb[i]),
      .soft_reset (soft_reset[i])
    );
  end

  assign write_enb = addr_hot & {NUM_PORTS{write_enb_reg}};
  assign fifo_full = |(full & addr_hot);
  assign vld_out   = ~empty;

endmodule

// File: tb/tb_router_sync.sv
module tb_router_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] datain;
  logic       write_enb_reg;
  logic [2:0] read_enb, empty, full;
  logic [2:0] write_enb, vld_out, soft_reset;
  logic       fifo_full, addr_err;

  router_sync #(.NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(30)) dut (
    .clk(clk), .reset(reset), .detect_add(detect_add), .datain(datain),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty),
    .full(full), .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out(vld_out), .soft_reset(soft_reset), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int sig; logic [2:0] exp; string name; } chk_t;
  typedef struct { int cyc; logic [2:0] vec; } pls_t;
  chk_t exp_q[$];
  pls_t pls_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [2:0] sample(int sig);
    case (sig)
      0:       return write_enb;
      1:       return {2'b00, fifo_full};
      2:       return {2'b00, addr_err};
      default: return soft_reset;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(string n, int sig, logic [2:0] e);
    chk_t c;
    c.cyc = cyc; c.sig = sig; c.exp = e; c.name = n;
    exp_q.push_back(c);
  endtask

  task automatic expect_pulse(int at, logic [2:0] v);
    pls_t p;
    p.cyc = at; p.vec = v;
    pls_q.push_back(p);
  endtask

  // Monitor: sampled checks due this cycle, plus every soft_reset pulse the
  // DUT raises must match the next expected pulse in cycle and port.
  always @(negedge clk) begin
    chk_t c;
    pls_t p;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      c = exp_q.pop_front();
      checks++;
      if (c.cyc != cyc) begin
        errors++;
        $display("FAIL %s: check not sampled (due cycle %0d, now %0d)", c.name, c.cyc, cyc);
      end else if (sample(c.sig) !== c.exp) begin
        errors++;
        $display("FAIL %s: cycle %0d got %b expected %b", c.name, cyc, sample(c.sig), c.exp);
      end
    end
    while (pls_q.size() > 0 && pls_q[0].cyc < cyc) begin
      p = pls_q.pop_front();
      checks++;
      errors++;
      $display("FAIL soft_reset_missing: expected %b at cycle %0d, got none", p.vec, p.cyc);
    end
    if (cyc > 0 && soft_reset !== 3'b000) begin
      checks++;
      if (pls_q.size() > 0 && pls_q[0].cyc == cyc) begin
        p = pls_q.pop_front();
        if (soft_reset !== p.vec) begin
          errors++;
          $display("FAIL soft_reset_vec: cycle %0d got %b expected %b", cyc, soft_reset, p.vec);
        end
      end else begin
        errors++;
        $display("FAIL soft_reset_unexpected: cycle %0d got %b expected 000", cyc, soft_reset);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k0;
    // 1. reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      detect_add = 1'($urandom); datain = 2'($urandom); write_enb_reg = 1'($urandom);
      read_enb = 3'($urandom); empty = 3'($urandom); full = 3'($urandom);
      step();
      detect_add = 1'($urandom); datain = 2'($urandom); write_enb_reg = 1'($urandom);
      full = 3'($urandom);
      expect_now("rst_write_enb", 0, 3'b000);
      expect_now("rst_fifo_full", 1, 3'b000);
      expect_now("rst_addr_err", 2, 3'b000);
      expect_now("rst_soft_reset", 3, 3'b000);
    end
    step();
    reset = 1'b0; detect_add = 1'b0; datain = 2'd0; write_enb_reg = 1'b0;
    read_enb = 3'b000; empty = 3'b111; full = 3'b000;
    step();

    // 2. address 2, decode, full steering, simultaneous detect uses old address
    detect_add = 1'b1; datain = 2'd2; write_enb_reg = 1'b1;
    expect_now("we_before_latch", 0, 3'b000);
    step();
    detect_add = 1'b0; full = 3'b100;
    expect_now("we_port2", 0, 3'b100);
    expect_now("ff_port2_full", 1, 3'b001);
    step();
    full = 3'b001;
    expect_now("ff_other_full", 1, 3'b000);
    step();
    detect_add = 1'b1; datain = 2'd0;
    expect_now("we_old_addr", 0, 3'b100);
    step();
    detect_add = 1'b0;
    expect_now("we_new_addr", 0, 3'b001);
    step();
    write_enb_reg = 1'b0;
    expect_now("we_idle", 0, 3'b000);

    // 3. invalid address 3
    detect_add = 1'b1; datain = 2'd3;
    step();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
    expect_now("addr_err_pulse", 2, 3'b001);
    expect_now("we_bad_addr", 0, 3'b000);
    expect_now("ff_bad_addr", 1, 3'b000);
    step();
    expect_now("addr_err_clear", 2, 3'b000);
    expect_now("we_bad_addr_hold", 0, 3'b000);
    step();
    write_enb_reg = 1'b0; full = 3'b000;
    repeat (2) step();

    // 4. port1 valid and unread for 30 edges
    k0 = cyc;
    empty = 3'b101;
    expect_pulse(k0 + 30, 3'b010);
    repeat (30) step();
    empty = 3'b111;
    repeat (3) step();

    // 5. read at edge 20 restarts the window
    k0 = cyc;
    empty = 3'b101;
    expect_pulse(k0 + 50, 3'b010);
    repeat (19) step();
    read_enb = 3'b010;
    step();
    read_enb = 3'b000;
    repeat (30) step();
    empty = 3'b111;
    repeat (3) step();

    // 6. reset mid-count and mid-packet
    detect_add = 1'b1; datain = 2'd0;
    step();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    expect_now("we_before_rst", 0, 3'b001);
    step();
    write_enb_reg = 1'b0;
    k0 = cyc;
    empty = 3'b101;
    expect_pulse(k0 + 45, 3'b010);
    repeat (14) step();
    reset = 1'b1;
    step();
    reset = 1'b0; write_enb_reg = 1'b1; full = 3'b001;
    expect_now("we_after_rst", 0, 3'b000);
    expect_now("ff_after_rst", 1, 3'b000);
    step();
    write_enb_reg = 1'b0; full = 3'b000;
    repeat (29) step();
    empty = 3'b111;
    repeat (4) step();

    if (exp_q.size() != 0 || pls_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d checks and %0d pulses pending, expected 0", exp_q.size(), pls_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
